// File: rtl/router_datapath_reg.sv
// ============================================================================
// Module   : router_datapath_reg
// Brief    : Router register datapath: header/full-hold capture, dout
//            steering, running parity, packet-parity compare and error flag.
//            Optional saturating error counter under ROUTER_REG_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_datapath_reg (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       fifo_full,
    input  logic       rst_int_reg,
    input  logic       detect_add,
    input  logic       lfd_state,
    input  logic       ld_state,
    input  logic       laf_state,
    input  logic       full_state,
    output logic       parity_done,
    output logic       low_packet_valid,
    output logic       err,
    output logic [7:0] dout
`ifdef ROUTER_REG_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    logic [7:0] r_header;
    logic [7:0] r_full_hold;
    logic [7:0] r_int_parity;
    logic [7:0] r_pkt_parity;
    logic       w_addr_invalid;
    logic       w_hdr_load;
    logic       w_da_clr;
    logic       w_mismatch;

    // An invalid-address header byte must leave every register untouched,
    // so it also suppresses the detect_add clears.
    assign w_addr_invalid = pkt_valid && (data_in[1:0] == 2'b11);
    assign w_hdr_load     = detect_add && pkt_valid && !w_addr_invalid;
    assign w_da_clr       = detect_add && !w_addr_invalid;
    assign w_mismatch     = (r_int_parity != r_pkt_parity);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_header    <= 8'h00;
            r_full_hold <= 8'h00;
            dout        <= 8'h00;
        end else begin
            if (w_hdr_load)
                r_header <= data_in;
            if (ld_state && fifo_full)
                r_full_hold <= data_in;
            if (lfd_state)
                dout <= r_header;
            else if (ld_state && !fifo_full)
                dout <= data_in;
            else if (laf_state)
                dout <= r_full_hold;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_int_parity     <= 8'h00;
            r_pkt_parity     <= 8'h00;
            parity_done      <= 1'b0;
            low_packet_valid <= 1'b0;
            err              <= 1'b0;
        end else begin
            if (w_da_clr)
                r_int_parity <= 8'h00;
            else if (lfd_state)
                r_int_parity <= r_int_parity ^ r_header;
            else if (ld_state && pkt_valid && !full_state)
                r_int_parity <= r_int_parity ^ data_in;

            if (w_da_clr)
                r_pkt_parity <= 8'h00;
            else if (ld_state && !pkt_valid)
                r_pkt_parity <= data_in;

            if (w_da_clr)
                parity_done <= 1'b0;
            else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_packet_valid && !parity_done))
                parity_done <= 1'b1;

            if (rst_int_reg)
                low_packet_valid <= 1'b0;
            else if (ld_state && !pkt_valid)
                low_packet_valid <= 1'b1;

            // err is deliberately not cleared by detect_add.
            if (parity_done)
                err <= w_mismatch;
        end
    end

`ifdef ROUTER_REG_ERR_CNT_EN
    logic r_parity_done_d;

    // One count per compare: parity_done stays high until the next header,
    // so only its first cycle is counted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_parity_done_d <= 1'b0;
            err_count       <= 8'h00;
        end else begin
            r_parity_done_d <= parity_done;
            if (parity_done && !r_parity_done_d && w_mismatch && (err_count != 8'hFF))
                err_count <= err_count + 8'h01;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_router_datapath_reg.sv
// Directed self-checking bench for router_datapath_reg.
`default_nettype none

module tb_router_datapath_reg;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       detect_add = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       parity_done;
    logic       low_packet_valid;
    logic       err;
    logic [7:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    router_datapath_reg dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .rst_int_reg      (rst_int_reg),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err),
        .dout             (dout)
`ifdef ROUTER_REG_ERR_CNT_EN
        ,
        .err_count        (err_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of strobes, then sample 1 time unit after the edge.
    task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                         input logic pv, input logic ff, input logic [7:0] din);
        detect_add = da;
        lfd_state  = lfd;
        ld_state   = ld;
        laf_state  = laf;
        pkt_valid  = pv;
        fifo_full  = ff;
        data_in    = din;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic clr_lpv();
        rst_int_reg = 1'b1;
        idle();
        rst_int_reg = 1'b0;
    endtask

    // Header 0C, payload 01 02 03, then the given parity byte, then one idle.
    task automatic send_pkt(input logic [7:0] par);
        drive(1, 0, 0, 0, 1, 0, 8'h0C);
        drive(0, 1, 0, 0, 1, 0, 8'h01);
        drive(0, 0, 1, 0, 1, 0, 8'h01);
        drive(0, 0, 1, 0, 1, 0, 8'h02);
        drive(0, 0, 1, 0, 1, 0, 8'h03);
        drive(0, 0, 1, 0, 0, 0, par);
        idle();
        clr_lpv();
    endtask

    initial begin
        #12;
        check("reset_dout", dout, 8'h00);
        check("reset_pdone", parity_done, 0);
        check("reset_err", err, 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Good packet
        drive(1, 0, 0, 0, 1, 0, 8'h0C);
        drive(0, 1, 0, 0, 1, 0, 8'h01);
        check("good_dout_hdr", dout, 8'h0C);
        drive(0, 0, 1, 0, 1, 0, 8'h01);
        check("good_dout_b1", dout, 8'h01);
        drive(0, 0, 1, 0, 1, 0, 8'h02);
        check("good_dout_b2", dout, 8'h02);
        drive(0, 0, 1, 0, 1, 0, 8'h03);
        check("good_dout_b3", dout, 8'h03);
        check("good_pdone_early", parity_done, 0);
        drive(0, 0, 1, 0, 0, 0, 8'h0C);
        check("good_pdone", parity_done, 1);
        check("good_lpv", low_packet_valid, 1);
        idle();
        check("good_err", err, 0);
        clr_lpv();
        check("good_lpv_clr", low_packet_valid, 0);

        // FIFO full mid-packet
        drive(1, 0, 0, 0, 1, 0, 8'h0C);
        drive(0, 1, 0, 0, 1, 0, 8'h01);
        drive(0, 0, 1, 0, 1, 0, 8'h01);
        drive(0, 0, 1, 0, 1, 1, 8'h02);
        check("ff_dout_hold", dout, 8'h01);
        drive(0, 0, 0, 1, 1, 0, 8'h02);
        check("ff_dout_laf", dout, 8'h02);
        drive(0, 0, 1, 0, 1, 0, 8'h03);
        drive(0, 0, 1, 0, 0, 0, 8'h0C);
        check("ff_pdone", parity_done, 1);
        idle();
        check("ff_err_parity", err, 0);
        clr_lpv();

        // Low packet finished in LAF: parity 0C^01 = 0D
        drive(1, 0, 0, 0, 1, 0, 8'h0C);
        drive(0, 1, 0, 0, 1, 0, 8'h01);
        drive(0, 0, 1, 0, 1, 0, 8'h01);
        drive(0, 0, 1, 0, 0, 1, 8'h0D);
        check("lp_pdone_wait", parity_done, 0);
        check("lp_lpv", low_packet_valid, 1);
        check("lp_dout_hold", dout, 8'h01);
        drive(0, 0, 0, 1, 0, 0, 8'h00);
        check("lp_pdone", parity_done, 1);
        check("lp_dout_laf", dout, 8'h0D);
        idle();
        check("lp_err", err, 0);
        clr_lpv();
        check("lp_lpv_clr", low_packet_valid, 0);

        // Invalid address leaves header register untouched
        drive(1, 0, 0, 0, 1, 0, 8'h09);
        drive(1, 0, 0, 0, 1, 0, 8'h0F);
        drive(0, 1, 0, 0, 1, 0, 8'h00);
        check("inv_addr_hdr", dout, 8'h09);
        idle();

        // Bad parity
        send_pkt(8'hFF);
        check("bad_err", err, 1);
        drive(1, 0, 0, 0, 1, 0, 8'h0C);
        check("bad_err_hold_da", err, 1);
        check("bad_pdone_clr", parity_done, 0);
`ifdef ROUTER_REG_ERR_CNT_EN
        check("bad_err_count", err_count, 8'h01);
`endif

        // Asynchronous reset mid-payload
        drive(0, 1, 0, 0, 1, 0, 8'h01);
        drive(0, 0, 1, 0, 1, 0, 8'h05);
        check("rst_pre_dout", dout, 8'h05);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_dout", dout, 8'h00);
        check("rst_async_err", err, 0);
        check("rst_async_lpv", low_packet_valid, 0);
        check("rst_async_pdone", parity_done, 0);
`ifdef ROUTER_REG_ERR_CNT_EN
        check("rst_async_cnt", err_count, 8'h00);
`endif
        resetn = 1'b1;
        idle();

        // Fresh packet after reset computes parity from scratch
        send_pkt(8'h0C);
        check("post_rst_err", err, 0);
        check("post_rst_dout", dout, 8'h0C);

`ifdef ROUTER_REG_ERR_CNT_EN
        for (int i = 0; i < 256; i++)
            send_pkt(8'hFF);
        check("sat_cnt", err_count, 8'hFF);
        send_pkt(8'hFF);
        check("sat_hold", err_count, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
